// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB-Lite arbiter: burst-boundary tracking, HLOCK ownership, registered grant/master outputs.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie-break; undefined gives fixed priority to master 0.
module ahb_arbiter_2m #(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned INCR_LIMIT     = 16
) (
    input  logic       HMASTCLOCK,
    input  logic       HRESET,
    input  logic [1:0] HBUSREQ,
    input  logic [1:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic [1:0] HGRANT,
    output logic       HMASTER,
    output logic       HMASTLOCK
);

    localparam int unsigned CW = $clog2(((INCR_LIMIT > 16) ? INCR_LIMIT : 16) + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BURST  = 2'd1;
    localparam logic [1:0] ST_INCR   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic       DEF_IDX   = (DEFAULT_MASTER == 1) ? 1'b1 : 1'b0;
    localparam logic [1:0] DEF_GRANT = (DEFAULT_MASTER == 1) ? 2'b10 : 2'b01;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [1:0]    w_track;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] r_len;
    logic [CW-1:0] w_len_nxt;
    logic [CW-1:0] w_new_len;
    logic [1:0]    r_grant;
    logic [1:0]    w_grant_nxt;
    logic          r_master;
    logic          r_mastlock;
    logic          w_owner;
    logic          w_arb;
    logic          w_keep_lock;
    logic          w_sel;
    logic          w_incr_act;
    logic          w_start;

    // Burst length in beats; zero encodes an undefined-length INCR.
    function automatic logic [CW-1:0] burst_len(input logic [2:0] hb);
        case (hb)
            3'b000:         burst_len = CW'(1);
            3'b001:         burst_len = '0;
            3'b010, 3'b011: burst_len = CW'(4);
            3'b100, 3'b101: burst_len = CW'(8);
            default:        burst_len = CW'(16);
        endcase
    endfunction

    assign w_owner     = r_grant[1];
    assign w_keep_lock = HLOCK[w_owner];
    assign w_new_len   = burst_len(HBURST);
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_start     = (HTRANS == TR_NONSEQ) || ((HTRANS == TR_SEQ) && (r_state == ST_IDLE));
    assign w_incr_act  = (r_state == ST_INCR) ||
                         ((r_state == ST_LOCKED) && (r_len == '0) && (r_cnt != '0));

    // Winner of an arbitration point when ownership is not locked.
    always_comb begin
        w_sel = DEF_IDX;
        case (HBUSREQ)
            2'b01: w_sel = 1'b0;
            2'b10: w_sel = 1'b1;
            2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
                w_sel = ~w_owner;
`else
                w_sel = 1'b0;
`endif
            end
            default: w_sel = DEF_IDX;
        endcase
    end

    // Beat tracking, arbitration-point detection and next state/grant.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_track     = r_state;
        w_arb       = 1'b0;
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        if (HREADY) begin
            if (HTRANS == TR_IDLE) begin
                w_cnt_nxt = '0;
                w_arb     = 1'b1;
                w_track   = ST_IDLE;
            end else if (w_start) begin
                w_len_nxt = (HTRANS == TR_NONSEQ) ? w_new_len : CW'(1);
                w_cnt_nxt = CW'(1);
                w_arb     = (w_len_nxt == CW'(1)) || ((HTRANS == TR_NONSEQ) && w_incr_act);
                if (w_len_nxt == CW'(1)) begin
                    w_track = ST_IDLE;
                end else if (w_len_nxt == '0) begin
                    w_track = ST_INCR;
                end else begin
                    w_track = ST_BURST;
                end
            end else if (HTRANS == TR_SEQ) begin
                w_cnt_nxt = w_cnt_inc;
                w_track   = (r_len == '0) ? ST_INCR : ST_BURST;
                if ((r_len != '0) && (w_cnt_inc == r_len)) begin
                    w_arb   = 1'b1;
                    w_track = ST_IDLE;
                end else if ((r_len == '0) && (w_cnt_inc == CW'(INCR_LIMIT)) &&
                             (r_state != ST_LOCKED)) begin
                    // Forced re-arbitration; the INCR may continue, so restart the beat count.
                    w_arb     = 1'b1;
                    w_cnt_nxt = '0;
                end
            end

            if (w_arb && w_keep_lock) begin
                w_state_nxt = ST_LOCKED;
            end else if (w_arb || (r_state != ST_LOCKED)) begin
                w_state_nxt = w_track;
            end

            if (w_arb && !w_keep_lock) begin
                w_grant_nxt = w_sel ? 2'b10 : 2'b01;
            end
        end
    end

    // State and output registers; everything holds while HREADY is low.
    always_ff @(posedge HMASTCLOCK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_grant    <= DEF_GRANT;
            r_master   <= DEF_IDX;
            r_mastlock <= 1'b0;
        end else if (HREADY) begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_grant    <= w_grant_nxt;
            r_master   <= w_owner;
            r_mastlock <= w_keep_lock;
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Scoreboard bench for ahb_arbiter_2m; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_ahb_arbiter_2m;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [1:0] G0 = 2'b01;
    localparam logic [1:0] G1 = 2'b10;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] hbusreq;
    logic [1:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hgrant;
    logic       hmaster;
    logic       hmastlock;

    typedef struct {
        logic [1:0] g;
        logic       m;
        logic       ml;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ahb_arbiter_2m #(
        .DEFAULT_MASTER(0),
        .INCR_LIMIT    (16)
    ) dut (
        .HMASTCLOCK(clk),
        .HRESET    (rst),
        .HBUSREQ   (hbusreq),
        .HLOCK     (hlock),
        .HTRANS    (htrans),
        .HBURST    (hburst),
        .HREADY    (hready),
        .HGRANT    (hgrant),
        .HMASTER   (hmaster),
        .HMASTLOCK (hmastlock)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_grant"}, 8'(hgrant), 8'(e.g));
        check({e.tag, "_master"}, 8'(hmaster), 8'(e.m));
        check({e.tag, "_mastlock"}, 8'(hmastlock), 8'(e.ml));
    endtask

    task automatic expect_now(input logic [1:0] eg, input logic em, input logic eml, input string tag);
        exp_t e;
        e = '{eg, em, eml, tag};
        sb_q.push_back(e);
        compare_front();
    endtask

    // Drive one bus cycle, queue the outputs expected after the edge, then compare.
    task automatic step(input logic [1:0] breq, input logic [1:0] lck, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rd,
                        input logic [1:0] eg, input logic em, input logic eml, input string tag);
        exp_t e;
        hbusreq = breq;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rd;
        e = '{eg, em, eml, tag};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic gi;
        logic prev;
        logic mi;

        rst = 1'b1; hbusreq = 2'b00; hlock = 2'b00; htrans = T_IDLE; hburst = B_SINGLE; hready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_now(G0, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "park");

        // M1 alone, single transfers
        step(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1, G1, 1'b0, 1'b0, "m1_req");
        step(2'b10, 2'b00, T_NSEQ, B_SINGLE, 1'b1, G1, 1'b1, 1'b0, "m1_single0");
        step(2'b10, 2'b00, T_NSEQ, B_SINGLE, 1'b1, G1, 1'b1, 1'b0, "m1_single1");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b1, 1'b0, "m1_release");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "m1_parked");

        // M0 INCR8 with M1 requesting from beat 3, a BUSY and a wait stretch on the last beat
        step(2'b01, 2'b00, T_NSEQ, B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b1");
        step(2'b01, 2'b00, T_SEQ,  B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b2");
        step(2'b10, 2'b00, T_SEQ,  B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b3");
        step(2'b10, 2'b00, T_SEQ,  B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b4");
        step(2'b10, 2'b00, T_BUSY, B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_busy");
        step(2'b10, 2'b00, T_SEQ,  B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b5");
        step(2'b10, 2'b00, T_SEQ,  B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b6");
        step(2'b10, 2'b00, T_SEQ,  B_INCR8, 1'b1, G0, 1'b0, 1'b0, "incr8_b7");
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 2'b00, T_SEQ, B_INCR8, 1'b0, G0, 1'b0, 1'b0, "incr8_wait");
        end
        step(2'b10, 2'b00, T_SEQ,  B_INCR8, 1'b1, G1, 1'b0, 1'b0, "incr8_b8");
        step(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1, G1, 1'b1, 1'b0, "incr8_handover");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b1, 1'b0, "incr8_release");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "incr8_parked");

        // Undefined-length INCR forced to re-arbitrate at the beat limit
        step(2'b01, 2'b00, T_NSEQ, B_INCR, 1'b1, G0, 1'b0, 1'b0, "incr_b1");
        for (int b = 2; b <= 15; b++) begin
            step(2'b10, 2'b00, T_SEQ, B_INCR, 1'b1, G0, 1'b0, 1'b0, "incr_mid");
        end
        step(2'b10, 2'b00, T_SEQ,  B_INCR,   1'b1, G1, 1'b0, 1'b0, "incr_limit");
        step(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1, G1, 1'b1, 1'b0, "incr_handover");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b1, 1'b0, "incr_release");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "incr_parked");

        // Locked INCR4 x3 from M0 while M1 requests, then one unlocked INCR4
        step(2'b11, 2'b01, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b1, "lock_enter");
        for (int k = 0; k < 3; k++) begin
            step((k == 0) ? 2'b11 : 2'b10, 2'b01, T_NSEQ, B_INCR4, 1'b1, G0, 1'b0, 1'b1, "lock_nseq");
            for (int s = 0; s < 3; s++) begin
                step((k == 0) ? 2'b11 : 2'b10, 2'b01, T_SEQ, B_INCR4, 1'b1, G0, 1'b0, 1'b1, "lock_seq");
            end
        end
        step(2'b10, 2'b00, T_NSEQ, B_INCR4, 1'b1, G0, 1'b0, 1'b0, "unlock_b1");
        step(2'b10, 2'b00, T_SEQ,  B_INCR4, 1'b1, G0, 1'b0, 1'b0, "unlock_b2");
        step(2'b10, 2'b00, T_SEQ,  B_INCR4, 1'b1, G0, 1'b0, 1'b0, "unlock_b3");
        step(2'b10, 2'b00, T_SEQ,  B_INCR4, 1'b1, G1, 1'b0, 1'b0, "unlock_b4");
        step(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1, G1, 1'b1, 1'b0, "unlock_handover");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b1, 1'b0, "unlock_release");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "unlock_parked");

        // Both masters streaming singles; tie-break per build, with a 3-cycle wait freeze
        gi = 1'b0;
        mi = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k >= 6 && k < 9) begin
                step(2'b11, 2'b00, T_NSEQ, B_SINGLE, 1'b0, gi ? G1 : G0, mi, 1'b0, "tie_frozen");
            end else begin
                prev = gi;
                gi   = RR ? ~gi : 1'b0;
                mi   = prev;
                step(2'b11, 2'b00, T_NSEQ, B_SINGLE, 1'b1, gi ? G1 : G0, mi, 1'b0, "tie_single");
            end
        end
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, gi, 1'b0, "tie_release");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "tie_parked");

        // Reset in the middle of an M1 burst
        step(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1, G1, 1'b0, 1'b0, "rst_req");
        step(2'b10, 2'b00, T_NSEQ, B_INCR4,  1'b1, G1, 1'b1, 1'b0, "rst_b1");
        step(2'b10, 2'b00, T_SEQ,  B_INCR4,  1'b1, G1, 1'b1, 1'b0, "rst_b2");
        #3;
        rst = 1'b1;
        #1;
        expect_now(G0, 1'b0, 1'b0, "reset_mid");
        hbusreq = 2'b00; htrans = T_IDLE; hburst = B_SINGLE;
        @(posedge clk);
        #1;
        expect_now(G0, 1'b0, 1'b0, "reset_hold");
        rst = 1'b0;
        // A SEQ straight after reset is taken as a single NONSEQ and is an arbitration point
        step(2'b10, 2'b00, T_SEQ,  B_INCR4,  1'b1, G1, 1'b0, 1'b0, "seq_after_idle");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b1, 1'b0, "final_release");
        step(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1, G0, 1'b0, 1'b0, "final_parked");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
